sfp_link_monitor: RTL and testbench

- Parametrised multi-channel SFP link supervisor for the 10G Ethernet test designs.
- Per channel: debounces PCS block lock into a qualified link-up, counts good frames, bad frames and link drops, and exposes them through a one-cycle-latency read port.
- Drives the two board status LEDs (link, activity/error).
- Sits beside the per-SFP MAC/PCS instances; all inputs are already synchronous to sysclk_100m.

---
 rtl/sfp_mon_pkg.sv | 21 ++
 rtl/sfp_link_chan.sv | 91 +++++++++
 rtl/sfp_link_monitor.sv | 141 ++++++++++++++
 tb/tb_sfp_link_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_mon_pkg.sv
// Shared types and helpers for the SFP link monitor.
// Combinational only; no latency, no backpressure.
package sfp_mon_pkg;

    typedef enum logic [1:0] {
        DOWN = 2'd0,
        QUAL = 2'd1,
        UP   = 2'd2
    } link_state_t;

    localparam int LED_LINK = 0;
    localparam int LED_ACT  = 1;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_v) ? max_v : val + 32'd1;
    endfunction

endpackage

// File: rtl/sfp_link_chan.sv
// One SFP channel: lock debounce FSM, link-up register and saturating good/bad/drop counters.
// link_up one cycle after lock qualifies or drops; counters update every cycle; no backpressure.
module sfp_link_chan
    import sfp_mon_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lock,
    input  logic             i_rx_good,
    input  logic             i_rx_bad,
    input  logic             i_cnt_clear,
    output logic             o_link_up,
    output logic             o_link_nxt,
    output logic             o_drop,
    output logic [CNT_W-1:0] o_good,
    output logic [CNT_W-1:0] o_bad,
    output logic [CNT_W-1:0] o_drops
);

    localparam int               TMR_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEBOUNCE_CYC - 1);

    link_state_t      r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_link_up;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_bad;
    logic [CNT_W-1:0] r_drops;
    logic             w_qual_done;

    assign w_qual_done = (r_state == QUAL) && i_lock && (r_timer == TMR_LAST);
    assign o_drop      = (r_state == UP) && !i_lock;
    // Next-cycle link state, used by the top so the LEDs track link_up without extra lag.
    assign o_link_nxt  = w_qual_done || ((r_state == UP) && i_lock);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= DOWN;
            r_timer   <= '0;
            r_link_up <= 1'b0;
        end else begin
            r_link_up <= o_link_nxt;
            case (r_state)
                DOWN: begin
                    if (i_lock) begin
                        r_state <= QUAL;
                        r_timer <= '0;
                    end
                end
                QUAL: begin
                    if (!i_lock)
                        r_state <= DOWN;
                    else if (r_timer == TMR_LAST)
                        r_state <= UP;
                    else
                        r_timer <= r_timer + 1'b1;
                end
                UP: begin
                    if (!i_lock)
                        r_state <= DOWN;
                end
                default: r_state <= DOWN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_good  <= '0;
            r_bad   <= '0;
            r_drops <= '0;
        end else if (i_cnt_clear) begin
            r_good  <= '0;
            r_bad   <= '0;
            r_drops <= '0;
        end else begin
            if (i_rx_good) r_good  <= CNT_W'(sat_inc(32'(r_good), CNT_W));
            if (i_rx_bad)  r_bad   <= CNT_W'(sat_inc(32'(r_bad), CNT_W));
            if (o_drop)    r_drops <= CNT_W'(sat_inc(32'(r_drops), CNT_W));
        end
    end

    assign o_link_up = r_link_up;
    assign o_good    = r_good;
    assign o_bad     = r_bad;
    assign o_drops   = r_drops;

endmodule

// File: rtl/sfp_link_monitor.sv
// Multi-channel SFP link supervisor: per-channel link qualification, counter read port, status LEDs.
// Read data one cycle after rd_req, LEDs one cycle after their causes; no backpressure.
module sfp_link_monitor
    import sfp_mon_pkg::*;
#(
    parameter int SFP_COUNT       = 1,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYC    = 1000000,
    parameter int BLINK_CYC       = 25000000,
    parameter int ACT_STRETCH_CYC = 5000000,
    parameter int CHAN_W          = $clog2(SFP_COUNT > 1 ? SFP_COUNT : 2)
) (
    input  logic                 sysclk_100m,
    input  logic                 sys_reset_n,
    input  logic [SFP_COUNT-1:0] sfp_block_lock,
    input  logic [SFP_COUNT-1:0] sfp_rx_good,
    input  logic [SFP_COUNT-1:0] sfp_rx_bad,
    input  logic                 cnt_clear,
    input  logic                 rd_req,
    input  logic [CHAN_W-1:0]    rd_chan,
    output logic                 rd_ack,
    output logic [CNT_W-1:0]     rd_good,
    output logic [CNT_W-1:0]     rd_bad,
    output logic [CNT_W-1:0]     rd_drops,
    output logic                 rd_link_up,
    output logic [SFP_COUNT-1:0] link_up,
    output logic [1:0]           sleds
);

    localparam int                BL_W    = $clog2(BLINK_CYC + 1);
    localparam logic [BL_W-1:0]   BL_LAST = BL_W'(BLINK_CYC - 1);
    localparam int                ST_W    = $clog2(ACT_STRETCH_CYC + 1);
    localparam logic [ST_W-1:0]   ST_LOAD = ST_W'(ACT_STRETCH_CYC);
    localparam logic [CHAN_W:0]   N_CHAN  = (CHAN_W + 1)'(SFP_COUNT);

    logic [SFP_COUNT-1:0]            w_link_up;
    logic [SFP_COUNT-1:0]            w_link_nxt;
    logic [SFP_COUNT-1:0]            w_drop;
    logic [SFP_COUNT-1:0][CNT_W-1:0] w_good;
    logic [SFP_COUNT-1:0][CNT_W-1:0] w_bad;
    logic [SFP_COUNT-1:0][CNT_W-1:0] w_drops;

    for (genvar g = 0; g < SFP_COUNT; g++) begin : g_chan
        sfp_link_chan #(
            .CNT_W        (CNT_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_chan (
            .i_clk       (sysclk_100m),
            .i_rst_n     (sys_reset_n),
            .i_lock      (sfp_block_lock[g]),
            .i_rx_good   (sfp_rx_good[g]),
            .i_rx_bad    (sfp_rx_bad[g]),
            .i_cnt_clear (cnt_clear),
            .o_link_up   (w_link_up[g]),
            .o_link_nxt  (w_link_nxt[g]),
            .o_drop      (w_drop[g]),
            .o_good      (w_good[g]),
            .o_bad       (w_bad[g]),
            .o_drops     (w_drops[g])
        );
    end

    logic             r_rd_ack;
    logic [CNT_W-1:0] r_rd_good;
    logic [CNT_W-1:0] r_rd_bad;
    logic [CNT_W-1:0] r_rd_drops;
    logic             r_rd_link;
    logic [BL_W-1:0]  r_blink_cnt;
    logic             r_phase;
    logic [ST_W-1:0]  r_stretch;
    logic             r_err;
    logic [1:0]       r_sleds;

    logic             w_chan_ok;
    logic             w_phase_nxt;
    logic [ST_W-1:0]  w_stretch_nxt;
    logic             w_err_nxt;
    logic [1:0]       w_sleds_nxt;

    assign w_chan_ok = ({1'b0, rd_chan} < N_CHAN);

    // Captures pre-update counter values; out-of-range channels read as zero.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_rd_ack   <= 1'b0;
            r_rd_good  <= '0;
            r_rd_bad   <= '0;
            r_rd_drops <= '0;
            r_rd_link  <= 1'b0;
        end else begin
            r_rd_ack <= rd_req;
            if (rd_req) begin
                r_rd_good  <= w_chan_ok ? w_good[rd_chan]    : '0;
                r_rd_bad   <= w_chan_ok ? w_bad[rd_chan]     : '0;
                r_rd_drops <= w_chan_ok ? w_drops[rd_chan]   : '0;
                r_rd_link  <= w_chan_ok ? w_link_up[rd_chan] : 1'b0;
            end
        end
    end

    always_comb begin
        w_phase_nxt   = (r_blink_cnt == BL_LAST) ? ~r_phase : r_phase;
        w_stretch_nxt = r_stretch;
        if (|sfp_rx_good)
            w_stretch_nxt = ST_LOAD;
        else if (r_stretch != '0)
            w_stretch_nxt = r_stretch - 1'b1;
        w_err_nxt = cnt_clear ? 1'b0 : (r_err | (|sfp_rx_bad) | (|w_drop));
        w_sleds_nxt = '0;
        if (&w_link_nxt)
            w_sleds_nxt[LED_LINK] = 1'b1;
        else if (|w_link_nxt)
            w_sleds_nxt[LED_LINK] = w_phase_nxt;
        w_sleds_nxt[LED_ACT] = w_err_nxt ? w_phase_nxt : (w_stretch_nxt != '0);
    end

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_stretch   <= '0;
            r_err       <= 1'b0;
            r_sleds     <= '0;
        end else begin
            r_blink_cnt <= (r_blink_cnt == BL_LAST) ? '0 : r_blink_cnt + 1'b1;
            r_phase     <= w_phase_nxt;
            r_stretch   <= w_stretch_nxt;
            r_err       <= w_err_nxt;
            r_sleds     <= w_sleds_nxt;
        end
    end

    assign rd_ack     = r_rd_ack;
    assign rd_good    = r_rd_good;
    assign rd_bad     = r_rd_bad;
    assign rd_drops   = r_rd_drops;
    assign rd_link_up = r_rd_link;
    assign link_up    = w_link_up;
    assign sleds      = r_sleds;

endmodule

// File: tb/tb_sfp_link_monitor.sv
// Bench for sfp_link_monitor: directed plus random stimulus against a behavioural model and read scoreboard.
module tb_sfp_link_monitor;

    localparam int NCH   = 2;
    localparam int CW    = 4;
    localparam int DEB   = 8;
    localparam int BLINK = 4;
    localparam int ACT   = 6;
    localparam int CMAX  = 15;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] lock, rx_good, rx_bad;
    logic           cnt_clear, rd_req;
    logic           rd_chan;
    logic           rd_ack, rd_link_up;
    logic [CW-1:0]  rd_good, rd_bad, rd_drops;
    logic [NCH-1:0] link_up;
    logic [1:0]     sleds;

    sfp_link_monitor #(
        .SFP_COUNT       (NCH),
        .CNT_W           (CW),
        .DEBOUNCE_CYC    (DEB),
        .BLINK_CYC       (BLINK),
        .ACT_STRETCH_CYC (ACT)
    ) dut (
        .sysclk_100m    (clk),
        .sys_reset_n    (rst_n),
        .sfp_block_lock (lock),
        .sfp_rx_good    (rx_good),
        .sfp_rx_bad     (rx_bad),
        .cnt_clear      (cnt_clear),
        .rd_req         (rd_req),
        .rd_chan        (rd_chan),
        .rd_ack         (rd_ack),
        .rd_good        (rd_good),
        .rd_bad         (rd_bad),
        .rd_drops       (rd_drops),
        .rd_link_up     (rd_link_up),
        .link_up        (link_up),
        .sleds          (sleds)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state after cyc clock edges since reset release.
    typedef struct {
        int good;
        int bad;
        int drops;
        int link;
    } rd_exp_t;

    rd_exp_t q[$];
    int run[NCH]   = '{0, 0};
    int mup[NCH]   = '{0, 0};
    int mgood[NCH] = '{0, 0};
    int mbad[NCH]  = '{0, 0};
    int mdrop[NCH] = '{0, 0};
    int mlatch     = 0;
    int cyc        = 0;
    int last_good  = -1;

    function automatic int sat(input int v);
        return (v + 1 > CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int m_phase();
        return (cyc / BLINK) % 2;
    endfunction

    function automatic int exp_sleds();
        int l, a;
        if (mup[0] != 0 && mup[1] != 0)      l = 1;
        else if (mup[0] != 0 || mup[1] != 0) l = m_phase();
        else                                 l = 0;
        if (mlatch != 0) a = m_phase();
        else             a = (last_good > 0 && cyc - last_good < ACT) ? 1 : 0;
        return a * 2 + l;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        rd_exp_t e;
        int any_drop;
        int dropped[NCH];
        if (!rst_n) begin
            q.delete();
            for (int c = 0; c < NCH; c++) begin
                run[c] = 0; mup[c] = 0; mgood[c] = 0; mbad[c] = 0; mdrop[c] = 0;
            end
            mlatch = 0; cyc = 0; last_good = -1;
        end else begin
            if (rd_req) begin
                if (int'(rd_chan) < NCH) begin
                    e.good = mgood[rd_chan]; e.bad = mbad[rd_chan];
                    e.drops = mdrop[rd_chan]; e.link = mup[rd_chan];
                end else begin
                    e.good = 0; e.bad = 0; e.drops = 0; e.link = 0;
                end
                q.push_back(e);
            end
            any_drop = 0;
            for (int c = 0; c < NCH; c++) begin
                dropped[c] = (mup[c] != 0 && !lock[c]) ? 1 : 0;
                if (dropped[c] != 0) any_drop = 1;
                run[c] = lock[c] ? run[c] + 1 : 0;
                if (cnt_clear) begin
                    mgood[c] = 0; mbad[c] = 0; mdrop[c] = 0;
                end else begin
                    if (rx_good[c])      mgood[c] = sat(mgood[c]);
                    if (rx_bad[c])       mbad[c]  = sat(mbad[c]);
                    if (dropped[c] != 0) mdrop[c] = sat(mdrop[c]);
                end
                mup[c] = (run[c] >= DEB + 1) ? 1 : 0;
            end
            if (cnt_clear)                        mlatch = 0;
            else if ((|rx_bad) || any_drop != 0)  mlatch = 1;
            if (|rx_good) last_good = cyc + 1;
            cyc++;
        end
    end

    // Monitor: continuous link/LED check and read scoreboard.
    always @(negedge clk) begin
        rd_exp_t e;
        chk("link_up", 32'(link_up), 32'(mup[1] * 2 + mup[0]));
        chk("sleds", 32'(sleds), 32'(exp_sleds()));
        if (rd_ack === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'(rd_ack), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rd_good", 32'(rd_good), 32'(e.good));
                chk("rd_bad", 32'(rd_bad), 32'(e.bad));
                chk("rd_drops", 32'(rd_drops), 32'(e.drops));
                chk("rd_link_up", 32'(rd_link_up), 32'(e.link));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic ch);
        rd_req = 1'b1; rd_chan = ch;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; lock = '0; rx_good = '0; rx_bad = '0;
        cnt_clear = 1'b0; rd_req = 1'b0; rd_chan = 1'b0;
        repeat (3) tick();
        chk("reset_rd_ack", 32'(rd_ack), 32'd0);
        chk("reset_rd_good", 32'(rd_good), 32'd0);
        chk("reset_link_up", 32'(link_up), 32'd0);
        chk("reset_sleds", 32'(sleds), 32'd0);
        rst_n = 1'b1;

        // Short lock that never qualifies, then full qualification and a drop.
        lock[0] = 1'b1; repeat (5) tick();
        lock[0] = 1'b0; repeat (3) tick();
        do_read(1'b0); tick();
        lock[0] = 1'b1; repeat (12) tick();
        lock[0] = 1'b0; repeat (3) tick();
        do_read(1'b0); repeat (20) tick();

        // Saturation and simultaneous good/bad.
        for (int i = 0; i < 20; i++) begin
            rx_good[1] = 1'b1; tick();
        end
        rx_good = '0; do_read(1'b1);
        rx_good[0] = 1'b1; rx_bad[0] = 1'b1; tick();
        rx_good = '0; rx_bad = '0; do_read(1'b0); tick();

        // Clear coinciding with a good pulse and a read.
        cnt_clear = 1'b1; rx_good = 2'b11; rd_req = 1'b1; rd_chan = 1'b1; tick();
        cnt_clear = 1'b0; rx_good = '0; rd_req = 1'b0; tick();
        do_read(1'b1);

        // Back-to-back reads.
        rd_req = 1'b1; rd_chan = 1'b0; tick();
        rd_chan = 1'b1; tick();
        rd_req = 1'b0; repeat (2) tick();

        // One link up, then both.
        lock = 2'b01; repeat (22) tick();
        lock = 2'b11; repeat (14) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(29) == 0) lock[c] = ~lock[c];
            for (int c = 0; c < NCH; c++) begin
                rx_good[c] = ($urandom_range(3) == 0);
                rx_bad[c]  = ($urandom_range(15) == 0);
            end
            cnt_clear = ($urandom_range(99) == 0);
            rd_req    = ($urandom_range(2) == 0);
            rd_chan   = 1'($urandom_range(1));
            tick();
        end
        rx_good = '0; rx_bad = '0; cnt_clear = 1'b0; rd_req = 1'b0;

        // Reset asserted while a read ack is on the outputs.
        lock = 2'b11; repeat (14) tick();
        do_read(1'b0);
        chk("ack_before_reset", 32'(rd_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("async_rst_link_up", 32'(link_up), 32'd0);
        chk("async_rst_sleds", 32'(sleds), 32'd0);
        chk("async_rst_rd_data", 32'({rd_good, rd_bad, rd_drops, rd_link_up}), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("acks_pending", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
